// File: rtl/output_port_alloc.sv
// Output-port switch allocator for one direction of the 3D-torus router.
// Picks the farthest-travelled head flit (largest cmp), breaks ties round-robin,
// then holds the output for that packet until its tail leaves. Downstream
// buffer space is tracked per VC class with credit counters.
module output_port_alloc #(
  parameter int NUM_IN    = 7,
  parameter int CMP_W     = 8,
  parameter int BUF_DEPTH = 8,
  parameter int CRED_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN-1:0]       in_head,
  input  logic [NUM_IN-1:0]       in_tail,
  input  logic [NUM_IN-1:0]       in_vc,
  input  logic [NUM_IN*CMP_W-1:0] in_cmp,
  input  logic [1:0]              credit_ret,
  output logic [NUM_IN-1:0]       grant,
  output logic                    out_fire,
  output logic                    out_vc,
  output logic [NUM_IN-1:0]       stall_out,
  output logic                    cred_err
);

  localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(BUF_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic              out_vc_q, out_vc_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CRED_W-1:0] cred_q [2];
  logic              cred_err_q;

  logic [CMP_W-1:0]  cmp_arr [NUM_IN];
  logic [NUM_IN-1:0] cand;
  logic [1:0]        cred_avail;
  logic [1:0]        cred_dec;
  logic [CMP_W-1:0]  max_cmp;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic [PTR_W-1:0]  owner_idx;
  logic              owner_valid;
  logic              owner_tail;

  // Index base+off modulo NUM_IN; both operands are already below NUM_IN.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(off);
    if (s >= (PTR_W+1)'(NUM_IN))
      s = s - (PTR_W+1)'(NUM_IN);
    return s[PTR_W-1:0];
  endfunction

  // Credit counter update: a return and a consumption in the same cycle cancel;
  // a return into a full counter saturates (the error flag is raised separately).
  function automatic logic [CRED_W-1:0] cred_step(input logic [CRED_W-1:0] cur,
                                                  input logic inc, input logic dec);
    logic [CRED_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != CRED_FULL)
      nxt = cur + 1'b1;
    else if (dec && !inc)
      nxt = cur - 1'b1;
    return nxt;
  endfunction

  assign cred_avail[0] = (cred_q[0] != '0);
  assign cred_avail[1] = (cred_q[1] != '0);

  // Unpack cmp fields and form the head-flit request set for arbitration.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      cmp_arr[i] = in_cmp[i*CMP_W +: CMP_W];
      cand[i]    = in_valid[i] & in_head[i] & cred_avail[in_vc[i]];
    end
  end

  // Farthest-first search, then the first tied requester at or after rr_ptr.
  always_comb begin
    max_cmp   = '0;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cand[i] && cmp_arr[i] > max_cmp)
        max_cmp = cmp_arr[i];
    end
    for (int k = 0; k < NUM_IN; k++) begin
      scan_idx = wrap_add(rr_ptr_q, k);
      if (!win_found && cand[scan_idx] && cmp_arr[scan_idx] == max_cmp) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Decode the current owner and its flit attributes from the one-hot grant.
  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q[i])
        owner_idx = PTR_W'(i);
    end
    owner_valid = |(grant_q & in_valid);
    owner_tail  = |(grant_q & in_valid & in_tail);
  end

  assign out_fire    = (state_q == LOCKED) & owner_valid & cred_avail[out_vc_q];
  assign cred_dec[0] = out_fire & ~out_vc_q;
  assign cred_dec[1] = out_fire &  out_vc_q;

  // Next-state logic: arbitrate when idle, release after the owner's tail fires.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    out_vc_d = out_vc_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          out_vc_d         = in_vc[win_idx];
          state_d          = LOCKED;
        end
      end
      LOCKED: begin
        if (out_fire && owner_tail) begin
          grant_d  = '0;
          rr_ptr_d = wrap_add(owner_idx, 1);
          state_d  = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Allocator state registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      out_vc_q <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      out_vc_q <= out_vc_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Per-class downstream credit counters and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cred_q[0]  <= CRED_FULL;
      cred_q[1]  <= CRED_FULL;
      cred_err_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        cred_q[c] <= cred_step(cred_q[c], credit_ret[c], cred_dec[c]);
        if (credit_ret[c] && !cred_dec[c] && cred_q[c] == CRED_FULL)
          cred_err_q <= 1'b1;
      end
    end
  end

  assign grant     = grant_q;
  assign out_vc    = out_vc_q;
  assign cred_err  = cred_err_q;
  assign stall_out = in_valid & ~(grant_q & {NUM_IN{out_fire}});

endmodule

// File: tb/tb_output_port_alloc.sv
// Bench for output_port_alloc: packet sources per input, a transaction-level
// reference model, and a scoreboard monitor comparing every cycle's outputs.
module tb_output_port_alloc;

  localparam int N  = 7;
  localparam int CW = 8;
  localparam int BD = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_valid, in_head, in_tail, in_vc;
  logic [N*CW-1:0] in_cmp;
  logic [1:0]      credit_ret;
  logic [N-1:0]    grant, stall_out;
  logic            out_fire, out_vc, cred_err;

  always #5 clk = ~clk;

  output_port_alloc #(.NUM_IN(N), .CMP_W(CW), .BUF_DEPTH(BD), .CRED_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_head(in_head), .in_tail(in_tail),
    .in_vc(in_vc), .in_cmp(in_cmp), .credit_ret(credit_ret), .grant(grant),
    .out_fire(out_fire), .out_vc(out_vc), .stall_out(stall_out), .cred_err(cred_err)
  );

  typedef struct {int len; bit vc; int cmp;} pkt_t;
  typedef struct {
    logic [N-1:0] grant;
    logic [N-1:0] stall;
    logic         fire;
    logic         vc;
    logic         locked;
    logic         err;
  } exp_t;

  pkt_t srcq [N][$];
  int   pos  [N];
  exp_t expq [$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  // Reference model state: owner (-1 = free), round-robin start, credits.
  int m_owner = -1;
  int m_rr    = 0;
  int m_cred [2] = '{BD, BD};
  bit m_vc    = 1'b0;
  bit m_err   = 1'b0;
  int m_fires = 0;

  int         bubble_pct = 0;
  int         ret_mode   = 0;
  logic [1:0] ret_force  = 2'b00;

  bit           mon_en     = 1'b0;
  int           dut_fires  = 0;
  int           glog [$];
  logic [N-1:0] prev_grant = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_pkt(input int p, input int len, input bit vc, input int cmp);
    pkt_t k;
    k.len = len; k.vc = vc; k.cmp = cmp;
    srcq[p].push_back(k);
  endtask

  // Farthest-first: highest cmp wins; among equals, the one fewest steps past rr.
  function automatic int arb_winner();
    int best = -1, bc = 0, bdist = 0, c, d;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && in_head[i] && m_cred[in_vc[i]] > 0) begin
        c = int'(in_cmp[i*CW +: CW]);
        d = (i - m_rr + N) % N;
        if (best < 0 || c > bc || (c == bc && d < bdist)) begin
          best = i; bc = c; bdist = d;
        end
      end
    end
    return best;
  endfunction

  function automatic bit busy();
    bit b = (m_owner >= 0);
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  function automatic int enc_log();
    int v = 0;
    foreach (glog[k]) v = v * 10 + glog[k] + 1;
    return v;
  endfunction

  // One clock: drive sources, queue the expected outputs, advance the model.
  task automatic step();
    exp_t e;
    bit fire, dec;
    int n_owner, n_rr, n_cred [2], w, fired;
    bit n_vc, n_err;
    logic [1:0] ret;
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0 && $urandom_range(99) >= bubble_pct) begin
        in_valid[i] = 1'b1;
        in_head[i]  = (pos[i] == 0);
        in_tail[i]  = (pos[i] == srcq[i][0].len - 1);
        in_vc[i]    = srcq[i][0].vc;
        in_cmp[i*CW +: CW] = CW'(srcq[i][0].cmp);
      end else begin
        in_valid[i] = 1'b0; in_head[i] = 1'b0; in_tail[i] = 1'b0; in_vc[i] = 1'b0;
        in_cmp[i*CW +: CW] = '0;
      end
    end
    if (ret_mode != 0) begin
      ret[0] = ($urandom_range(2) == 0) && (m_cred[0] < BD);
      ret[1] = ($urandom_range(2) == 0) && (m_cred[1] < BD);
    end else begin
      ret = ret_force;
    end
    credit_ret = ret;

    fire     = (m_owner >= 0) && in_valid[m_owner] && (m_cred[m_vc] > 0);
    e.grant  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    e.stall  = in_valid & ~(fire ? e.grant : '0);
    e.fire   = fire;
    e.vc     = m_vc;
    e.locked = (m_owner >= 0);
    e.err    = m_err;
    expq.push_back(e);

    n_owner = m_owner; n_rr = m_rr; n_cred = m_cred; n_vc = m_vc; n_err = m_err;
    if (rst) begin
      n_owner = -1; n_rr = 0; n_cred[0] = BD; n_cred[1] = BD; n_vc = 1'b0; n_err = 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        dec = fire && (m_vc == c[0]);
        if (ret[c] && !dec) begin
          if (m_cred[c] == BD) n_err = 1'b1;
          else n_cred[c] = m_cred[c] + 1;
        end else if (dec && !ret[c]) begin
          n_cred[c] = m_cred[c] - 1;
        end
      end
      if (m_owner < 0) begin
        w = arb_winner();
        if (w >= 0) begin
          n_owner = w;
          n_vc    = in_vc[w];
        end
      end else if (fire && in_tail[m_owner]) begin
        n_rr    = (m_owner + 1) % N;
        n_owner = -1;
      end
    end
    fired = fire ? m_owner : -1;

    @(posedge clk);
    #1;
    m_owner = n_owner; m_rr = n_rr; m_cred = n_cred; m_vc = n_vc; m_err = n_err;
    if (fired >= 0) begin
      m_fires++;
      pos[fired]++;
      if (pos[fired] == srcq[fired][0].len) begin
        void'(srcq[fired].pop_front());
        pos[fired] = 0;
      end
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      pos[i] = 0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    glog.delete();
    bubble_pct = 0;
    ret_mode   = 0;
    ret_force  = 2'b00;
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (busy() && n < bound) begin
      step();
      n++;
    end
    chk({name, "_drain_timeout"}, 32'(busy()), 32'd0);
    repeat (3) step();
  endtask

  // Scoreboard monitor: pops one expected record per cycle, away from the edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: no expected record at %0t", $time);
      end else begin
        mon_e = expq.pop_front();
        chk("grant", 32'(grant), 32'(mon_e.grant));
        chk("out_fire", 32'(out_fire), 32'(mon_e.fire));
        chk("stall_out", 32'(stall_out), 32'(mon_e.stall));
        chk("cred_err", 32'(cred_err), 32'(mon_e.err));
        if (mon_e.locked) chk("out_vc", 32'(out_vc), 32'(mon_e.vc));
      end
      if (out_fire === 1'b1) dut_fires++;
      if (grant != '0 && prev_grant == '0) begin
        for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
      end
      prev_grant = grant;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0, n;
    rst = 1'b1;
    in_valid = '0; in_head = '0; in_tail = '0; in_vc = '0; in_cmp = '0;
    credit_ret = 2'b00;
    for (int i = 0; i < N; i++) pos[i] = 0;
    @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_out_fire", 32'(out_fire), 32'd0);
    chk("reset_out_vc", 32'(out_vc), 32'd0);
    chk("reset_cred_err", 32'(cred_err), 32'd0);
    mon_en = 1'b1;
    do_reset();

    // Single-flit packet on input 2, vc1.
    f0 = dut_fires;
    add_pkt(2, 1, 1'b1, 5);
    drain("single", 20);
    chk("single_order", 32'(enc_log()), 32'd3);
    chk("single_fires", 32'(dut_fires - f0), 32'd1);

    // Larger cmp wins; the loser is served after the winner's tail.
    do_reset();
    add_pkt(0, 4, 1'b0, 3);
    add_pkt(3, 4, 1'b0, 9);
    drain("priority", 40);
    chk("priority_order", 32'(enc_log()), 32'd41);

    // Equal cmp: round-robin 1, 4, 6, 1, 4, 6.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      add_pkt(1, 1, 1'b0, 7);
      add_pkt(4, 1, 1'b0, 7);
      add_pkt(6, 1, 1'b0, 7);
    end
    drain("rr", 40);
    chk("rr_order", 32'(enc_log()), 32'd257257);

    // Credit exhaustion: 8 fires, grant held, one returned credit gives one fire.
    do_reset();
    f0 = dut_fires;
    add_pkt(0, 10, 1'b0, 1);
    repeat (20) step();
    chk("exhaust_fires", 32'(dut_fires - f0), 32'd8);
    chk("exhaust_grant_held", 32'(grant), 32'd1);
    ret_force = 2'b01;
    step();
    ret_force = 2'b00;
    repeat (5) step();
    chk("exhaust_one_more", 32'(dut_fires - f0), 32'd9);
    ret_mode = 1;
    drain("exhaust", 60);

    // Fire and return on vc0 together; then an overflowing return on vc1.
    do_reset();
    add_pkt(0, 2, 1'b0, 2);
    step();
    ret_force = 2'b01;
    step();
    ret_force = 2'b00;
    step();
    ret_force = 2'b10;
    step();
    ret_force = 2'b00;
    repeat (3) step();
    chk("cred_err_sticky", 32'(cred_err), 32'd1);
    do_reset();
    chk("cred_err_cleared", 32'(cred_err), 32'd0);

    // Reset in the middle of a 5-flit packet, then a fresh packet.
    add_pkt(0, 5, 1'b1, 4);
    f0 = m_fires;
    n = 0;
    while (m_fires - f0 < 2 && n < 20) begin
      step();
      n++;
    end
    chk("midrst_reached", 32'(m_fires - f0), 32'd2);
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      pos[i] = 0;
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_out_vc", 32'(out_vc), 32'd0);
    add_pkt(5, 1, 1'b1, 2);
    drain("midrst", 20);
    chk("midrst_order", 32'(enc_log()), 32'd16);

    // Random traffic with bubbles, ties and random credit returns.
    do_reset();
    bubble_pct = 15;
    ret_mode   = 1;
    repeat (1500) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() == 0 && $urandom_range(7) == 0)
          add_pkt(i, int'($urandom_range(1, 5)), 1'($urandom_range(1)),
                  ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(3)));
      end
      step();
    end
    drain("random", 600);

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/output_port_alloc.md
Name: output_port_alloc

Overview:
- Per-output-port switch allocator for the 3D-torus router; one instance per output direction.
- Arbitrates among the seven input ports (XPOS, YPOS, ZPOS, XNEG, YNEG, ZNEG, INJECT) whose routed direction targets this output.
- Grants farthest-first using the head flit's cmp field, with round-robin tie-break, and holds the grant from head to tail.
- Tracks downstream credits per VC class; a flit moves only when a credit is available.

Parameters:
- NUM_IN, 7: number of requesting input ports.
- CMP_W, 8: width of the cmp priority field.
- BUF_DEPTH, 8: downstream buffer depth per VC class, i.e. the initial credit count.
- CRED_W, 4: credit counter width; must satisfy 2^CRED_W > BUF_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_valid  in  NUM_IN  input i has a flit at its RC stage output whose routed direction is this port.
- in_head  in  NUM_IN  that flit is HEAD or SINGLE.
- in_tail  in  NUM_IN  that flit is TAIL or SINGLE.
- in_vc  in  NUM_IN  VC class bit of input i's flit.
- in_cmp  in  NUM_IN*CMP_W  cmp field of input i's flit; input i occupies bits [i*CMP_W +: CMP_W].
- credit_ret  in  2  one credit returned for VC class 0 / 1.
- grant  out  NUM_IN  one-hot owner of this output; zero when idle.
- out_fire  out  1  combinational; owner's flit traverses the switch this cycle.
- out_vc  out  1  VC class locked for the current packet.
- stall_out  out  NUM_IN  per-input stall, fed to route_comp stall.
- cred_err  out  1  sticky; a credit was returned while the counter was full.

Behaviour:
- Reset (synchronous, active-high rst; clock clk):
  - state=IDLE, grant=0, out_vc=0, rr_ptr=0.
  - cred[0]=cred[1]=BUF_DEPTH, cred_err=0.
  - A reset mid-packet abandons the packet; the owner is released.
- FSM IDLE:
  - Candidate i = in_valid[i] & in_head[i] & (cred[in_vc[i]] != 0).
  - Winner = candidate with the maximum in_cmp, compared unsigned.
  - Ties go to the first tied candidate at or after rr_ptr, scanning upward mod NUM_IN.
  - If any candidate exists: next cycle grant=onehot(winner), out_vc=in_vc[winner], state=LOCKED.
  - Arbitration latency is 1 cycle; no flit fires in the arbitration cycle.
- FSM LOCKED, owner o:
  - out_fire = in_valid[o] & (cred[out_vc] != 0).
  - A non-head owner flit with in_valid low is a bubble: the grant is held and nothing fires.
  - On out_fire & in_tail[o]: next cycle grant=0, state=IDLE, rr_ptr=(o+1) mod NUM_IN.
  - SINGLE flits follow the same path: LOCKED for exactly one fire.
  - Requests from other inputs are ignored while LOCKED.
- stall_out[i]:
  - Asserted when in_valid[i] & ~(grant[i] & out_fire).
  - Deasserted when in_valid[i] is low.
- Credits, per class c:
  - Decrement when out_fire & out_vc==c.
  - Increment when credit_ret[c].
  - Both in the same cycle: count unchanged.
  - Never decremented below 0; this is guaranteed because fire requires nonzero credit.
  - Increment at BUF_DEPTH without a simultaneous decrement: saturate at BUF_DEPTH and set cred_err.
- Credit depletion mid-packet: the grant is held and the packet resumes when a credit returns; there is no preemption.
- Arithmetic:
  - rr_ptr is a ceil(log2 NUM_IN)-bit counter that wraps from NUM_IN-1 to 0.
  - The max-cmp search is combinational over NUM_IN entries.

Test Plan:
- Single-request win: rst; in_valid=7'b0000100, head+tail (SINGLE), vc=1, cmp=5 → grant=7'b0000100 one cycle later; out_fire=1, out_vc=1, cred[1] 8→7; grant=0 the following cycle.
- Priority, no lockout: inputs 0 and 3 both HEAD with cmp 3 and 9 → input 3 granted; input 0 stall_out=1 throughout input 3's 4-flit packet; input 0 granted after input 3's tail.
- Round-robin tie: inputs 1, 4, 6 each with cmp=7 and continuous single-flit packets → grant order 1, 4, 6, 1, with rr_ptr advancing 2, 5, 0.
- Credit exhaustion: 10-flit packet on vc0 with no credit_ret → exactly 8 fires, then out_fire=0 with grant held; one credit_ret[0] pulse → exactly one more fire.
- Simultaneous credit events: fire on vc0 in the same cycle as credit_ret[0] → cred[0] unchanged. credit_ret[1] at cred[1]=8 → cred[1] stays 8 and cred_err=1 (sticky until rst).
- Reset mid-packet: assert rst after flit 2 of a 5-flit packet → grant=0, cred=8/8, rr_ptr=0 next cycle; a new HEAD is arbitrated normally afterwards.
